// File: rtl/fifo_stream_pkg.sv
// Shared defaults and types for the FIFO read-side stream adapter.
package fifo_stream_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BURST_LEN  = 4;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;
  typedef logic [1:0]                skid_occ_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer; the head register drives the stream data directly.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output skid_occ_t             occ
);

  logic [DATA_WIDTH-1:0] tail_data;

  // The caller guarantees no push into a full buffer and no pop from an empty one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      tail_data <= '0;
      occ       <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head_data <= push_data;
          else             tail_data <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) head_data <= tail_data;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head_data <= tail_data;
            tail_data <= push_data;
          end else begin
            head_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a synchronous FIFO onto a valid/ready stream with burst framing,
// a delivered-beat counter and a sticky underflow flag.
module fifo_rd_stream_adapter
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  words_cnt,
  output logic                  err_underflow
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  skid_occ_t         occ;
  logic              inflight;
  logic              pop;
  logic [2:0]        pending;
  logic [BEAT_W-1:0] beat;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (beat == BEAT_MAX);
  assign pending = {1'b0, occ} + {2'b0, inflight};

  // A read may replace a word leaving this cycle, so m_ready feeds rd_en combinationally.
  assign fifo_rd_en = rst_n && enable && !fifo_empty &&
                      ((pending < 3'd2) || ((pending == 3'd2) && pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      beat          <= '0;
      words_cnt     <= '0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) begin
        beat      <= (beat == BEAT_MAX) ? '0 : beat + BEAT_W'(1);
        words_cnt <= words_cnt + CNT_WIDTH'(1);
      end
      if (fifo_underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed scoreboard bench for fifo_rd_stream_adapter with a behavioural FIFO model.
module tb_fifo_rd_stream_adapter;

  localparam int DW        = 16;
  localparam int BURST_LEN = 4;
  localparam int CW        = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic [CW-1:0] words_cnt;
  logic          err_underflow;

  logic          load_req = 1'b0;
  int            load_n = 0;
  logic          force_uf = 1'b0;
  logic          uf_reg = 1'b0;
  int            fifo_count = 0;
  logic [DW-1:0] fq[$];

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  int issued, delivered, model_beat, cyc, rd_cnt, first_rd, first_val, last_del, lost, n;

  fifo_rd_stream_adapter #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BURST_LEN),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .words_cnt      (words_cnt),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  assign fifo_empty     = (fifo_count == 0);
  assign fifo_underflow = uf_reg | force_uf;

  // Synchronous FIFO model with one-cycle registered read data; it ignores rst_n.
  always @(posedge clk) begin
    if (load_req) begin
      fq.delete();
      for (int i = 0; i < load_n; i++) fq.push_back(DW'(i + 1));
      uf_reg <= 1'b0;
    end else begin
      uf_reg <= fifo_rd_en && (fq.size() == 0);
      if (fifo_rd_en && fq.size() != 0) fifo_data_out <= fq.pop_front();
    end
    fifo_count <= fq.size();
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs after the falling edge, then sample and score what the next edge commits.
  task automatic applyStimulus(input logic en, input logic rdy);
    @(negedge clk);
    enable  = en;
    m_ready = rdy;
    #1;
    cyc++;
    checkOutput("words_cnt", words_cnt, delivered);
    if (fifo_rd_en) begin
      issued++;
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid) begin
      if (first_val < 0) first_val = cyc;
      checkOutput("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) checkOutput("m_data", m_data, exp_q[0]);
      checkOutput("m_last", m_last, model_beat == BURST_LEN - 1);
      if (m_ready) begin
        if (exp_q.size() != 0) exp_q.delete(0);
        delivered++;
        last_del   = cyc;
        model_beat = (model_beat == BURST_LEN - 1) ? 0 : model_beat + 1;
      end
    end else begin
      checkOutput("m_last_idle", m_last, 0);
    end
    checkOutput("skid_bound", (issued - delivered) <= 2, 1);
  endtask

  task automatic clearModel();
    issued = 0; delivered = 0; model_beat = 0; cyc = 0; rd_cnt = 0;
    first_rd = -1; first_val = -1; last_del = -1;
  endtask

  task automatic checkResetState();
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_words_cnt", words_cnt, 0);
    checkOutput("rst_err", err_underflow, 0);
    checkOutput("rst_rd_en", fifo_rd_en, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    enable  = 1'b0;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkResetState();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clearModel();
  endtask

  task automatic loadFifo(input int cnt);
    @(negedge clk);
    load_n   = cnt;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    exp_q.delete();
    for (int i = 0; i < cnt; i++) exp_q.push_back(DW'(i + 1));
  endtask

  task automatic drainAll(input bit toggle, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      applyStimulus(1'b1, toggle ? ((cyc % 2) == 0) : 1'b1);
      k++;
    end
    checkOutput("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    clearModel();

    $display("[TB] streaming at full rate");
    doReset();
    loadFifo(8);
    drainAll(1'b0, 40);
    checkOutput("latency", first_val - first_rd, 2);
    checkOutput("no_gaps", last_del - first_val, 7);
    applyStimulus(1'b0, 1'b1);
    checkOutput("words_cnt_final", words_cnt, 8);

    $display("[TB] backpressure stall");
    doReset();
    loadFifo(8);
    repeat (10) applyStimulus(1'b1, 1'b0);
    checkOutput("stall_rd_pulses", rd_cnt, 2);
    checkOutput("stall_held", m_valid, 1);
    drainAll(1'b0, 40);
    checkOutput("stall_delivered", delivered, 8);

    $display("[TB] toggling ready");
    doReset();
    loadFifo(8);
    drainAll(1'b1, 60);
    applyStimulus(1'b0, 1'b1);
    checkOutput("toggle_words_cnt", words_cnt, 8);

    $display("[TB] enable dropped after third read");
    doReset();
    loadFifo(8);
    for (int i = 0; i < 14; i++) applyStimulus(rd_cnt < 3, 1'b1);
    checkOutput("en_delivered", delivered, 3);
    checkOutput("en_valid_low", m_valid, 0);
    checkOutput("en_rd_pulses", rd_cnt, 3);
    checkOutput("en_fifo_left", fifo_count, 5);
    exp_q.delete();

    $display("[TB] asynchronous reset mid-burst");
    doReset();
    loadFifo(8);
    n = 0;
    while (delivered < 2 && n < 20) begin
      applyStimulus(1'b1, 1'b1);
      n++;
    end
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("pre_reset_occ", issued - delivered, 2);
    checkOutput("pre_reset_valid", m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState();
    lost = issued - delivered;
    for (int i = 0; i < lost; i++) if (exp_q.size() != 0) exp_q.delete(0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    drainAll(1'b0, 40);
    checkOutput("post_reset_delivered", delivered, 8 - 2 - lost);

    $display("[TB] sticky underflow");
    doReset();
    @(negedge clk);
    force_uf = 1'b1;
    @(negedge clk);
    force_uf = 1'b0;
    #1;
    checkOutput("uf_set", err_underflow, 1);
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("uf_sticky", err_underflow, 1);
    doReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream_adapter.md
Name: fifo_rd_stream_adapter

Overview:
- Downstream drain stage for the synchronous FIFO: issues `fifo_rd_en`, absorbs the FIFO's one-cycle registered read latency, and presents words on a valid/ready master stream.
- Adds burst framing (`m_last`), a delivered-word counter and a sticky underflow error flag.
- Sits between the FIFO read port and any stream consumer (serializer, packet builder).

Parameters:
- DATA_WIDTH, 16, width of FIFO data_out and m_data
- BURST_LEN, 4, beats per burst; m_last marks every BURST_LEN-th delivered beat (legal range 1..256)
- CNT_WIDTH, 16, width of words_cnt

Ports:
- clk  input  1  rising-edge clock shared with the FIFO
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  permits new FIFO reads; draining of already-fetched words continues regardless
- fifo_empty  input  1  FIFO empty flag
- fifo_underflow  input  1  FIFO underflow flag (registered by FIFO)
- fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted rd_en
- fifo_rd_en  output  1  read request to FIFO
- m_valid  output  1  stream data valid
- m_data  output  DATA_WIDTH  stream data
- m_last  output  1  last beat of a burst, qualified by m_valid
- m_ready  input  1  consumer ready
- words_cnt  output  CNT_WIDTH  number of beats transferred (m_valid && m_ready)
- err_underflow  output  1  sticky: set when fifo_underflow observed high

Behaviour:
- Reset (async, rst_n=0):
  - fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, words_cnt=0, err_underflow=0.
  - Skid buffer emptied, in-flight flag cleared, beat counter=0.
  - Reset mid-operation discards buffered and in-flight words; no recovery of lost data.
- State:
  - occ: 0..2, 2-entry skid buffer occupancy.
  - inflight: 1 bit, a read was issued last cycle.
  - beat: 0..BURST_LEN-1.
- pop = m_valid && m_ready.
- fifo_rd_en = enable && !fifo_empty && ((occ + inflight < 2) || (occ + inflight == 2 && pop)).
  - This is a combinational m_ready -> fifo_rd_en path, required for one word per cycle sustained throughput.
- inflight(next) = fifo_rd_en.
- Capture: when inflight=1, fifo_data_out is written into the skid tail at the edge.
  - Total latency from rd_en to earliest m_valid: 2 edges.
- Simultaneous capture and pop: occ unchanged; head advances, tail written.
- Skid capacity never exceeded: occ + inflight - pop <= 2 by construction. The bench asserts this.
- m_valid = (occ != 0); m_data = head entry; both registered outputs of the buffer.
- m_valid/m_data stay stable while m_valid && !m_ready (AXI-style rule).
- Ordering: strict FIFO order, no drops, no duplicates.
- m_last = m_valid && (beat == BURST_LEN-1).
  - beat increments on pop and wraps to 0 after BURST_LEN-1.
  - BURST_LEN=1 means m_last is high on every beat.
- words_cnt increments on pop and wraps modulo 2^CNT_WIDTH.
- err_underflow sets on any cycle with fifo_underflow=1 and clears only on reset. A correct adapter never causes underflow, so this flags integration faults.
- enable deassert: no further fifo_rd_en from the next evaluation; the in-flight word is still captured and buffered words still drain.
- fifo_empty while occ>0: the stream drains, then m_valid=0. No bubbles are inserted when the FIFO is non-empty and m_ready=1 continuously.
- Backpressure with m_ready=0: occ reaches 2, reads stop, and the FIFO fills, so the FIFO's full/almostfull flags become visible upstream.

Decomposition:
- Package fifo_stream_pkg: DATA_WIDTH default, BURST_LEN default, typedef data_t (logic [DATA_WIDTH-1:0]), typedef skid_occ_t (logic [1:0]).
- One natural sub-module: stream_skid_buf.
  - Function: 2-entry buffer, push/pop, head data, occ output.
  - The top holds read issue, inflight, beat/last, counters and error logic.

Test Plan:
- Reset then FIFO preloaded with 0x0001..0x0008, enable=1, m_ready=1 -> first m_valid 2 cycles after first rd_en; 8 consecutive beats 0x0001..0x0008 with no gaps; m_last on 0x0004 and 0x0008; words_cnt=8.
- Same preload, m_ready=0 for 10 cycles then 1 -> exactly 2 fifo_rd_en pulses during stall; m_data holds 0x0001 stable; after release all 8 delivered in order.
- m_ready toggled 1/0 every cycle on 8 words -> in-order delivery, occ never >2, words_cnt=8, m_last on beats 4 and 8.
- enable dropped on the cycle after the 3rd rd_en -> exactly 3 words delivered (0x0001..0x0003), then m_valid=0; no further rd_en while FIFO non-empty.
- rst_n asserted asynchronously mid-burst, between edges, with occ=2 -> all outputs 0 immediately; after release the next delivered word is the FIFO's current head; beat restarts at 0.
- Force fifo_underflow=1 for one cycle -> err_underflow=1 and stays 1 until rst_n=0.
